// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR MAC engine.
package fir_pkg;

  localparam int TAPE_NUM_DEFAULT = 11;
  localparam int BRAM_RD_LATENCY  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_MAC,
    S_DRAIN
  } fir_state_e;

endpackage

// File: rtl/fir_out_fifo.sv
// Two-entry output FIFO carrying {tlast, tdata}; push and pop may coincide.
module fir_out_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             axis_clk,
  input  logic             axis_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// Single-MAC FIR engine: AXI-Stream in/out, taps and sample history in external BRAMs.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = TAPE_NUM_DEFAULT
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_start,
  input  logic [31:0]            data_length,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A,
  input  logic [pDATA_WIDTH-1:0] data_Do,
  output logic                   ap_done,
  output logic                   ap_idle
);

  localparam logic [pADDR_WIDTH-1:0] TAPS    = pADDR_WIDTH'(Tape_Num);
  localparam logic [pADDR_WIDTH-1:0] TAPS_M1 = pADDR_WIDTH'(Tape_Num - 1);
  localparam logic [pADDR_WIDTH-1:0] LAT     = pADDR_WIDTH'(BRAM_RD_LATENCY);
  localparam logic [pADDR_WIDTH-1:0] LAST_K  = pADDR_WIDTH'(Tape_Num + BRAM_RD_LATENCY - 1);

  fir_state_e state, state_next;

  logic [pADDR_WIDTH-1:0] step;
  logic [pADDR_WIDTH-1:0] wptr;
  logic [pADDR_WIDTH-1:0] ring_idx;
  logic [pDATA_WIDTH-1:0] acc;
  logic [pDATA_WIDTH-1:0] prod;
  logic [pDATA_WIDTH-1:0] acc_sum;
  logic [31:0]            sample_cnt;
  logic [31:0]            cnt_next;
  logic [31:0]            len;
  logic                   last_seen;
  logic                   final_sample;
  logic                   in_hs;
  logic                   push;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [pDATA_WIDTH:0]   fifo_head;

  // Low half of the product is identical for signed and unsigned operands.
  assign prod         = tap_Do * data_Do;
  assign acc_sum      = acc + prod;
  assign cnt_next     = sample_cnt + 32'd1;
  assign final_sample = !(cnt_next < len) || last_seen;
  assign ring_idx     = (wptr >= step) ? (wptr - step) : (wptr + TAPS - step);
  assign in_hs        = (state == S_WAIT_IN) && ss_tvalid && !fifo_full;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state <= S_IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    ss_tready  = 1'b0;
    tap_EN     = 1'b0;
    tap_A      = '0;
    data_EN    = 1'b0;
    data_WE    = '0;
    data_Di    = '0;
    data_A     = '0;
    ap_done    = 1'b0;
    ap_idle    = 1'b0;
    push       = 1'b0;
    case (state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = '1;
        data_A  = step << 2;
        if (step == TAPS_M1) state_next = (len == '0) ? S_DRAIN : S_WAIT_IN;
      end
      S_WAIT_IN: begin
        ss_tready = !fifo_full;
        if (in_hs) begin
          data_EN    = 1'b1;
          data_WE    = '1;
          data_Di    = ss_tdata;
          data_A     = wptr << 2;
          state_next = S_MAC;
        end
      end
      S_MAC: begin
        // Reads run for Tape_Num cycles; the extra trailing cycle absorbs read latency.
        if (step < TAPS) begin
          tap_EN  = 1'b1;
          data_EN = 1'b1;
          tap_A   = step << 2;
          data_A  = ring_idx << 2;
        end
        if (step == LAST_K) begin
          push       = 1'b1;
          state_next = final_sample ? S_DRAIN : S_WAIT_IN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          ap_done    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      step       <= '0;
      wptr       <= '0;
      acc        <= '0;
      sample_cnt <= '0;
      len        <= '0;
      last_seen  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            len        <= data_length;
            sample_cnt <= '0;
            wptr       <= '0;
            step       <= '0;
            last_seen  <= 1'b0;
          end
        end
        S_CLEAR: begin
          step <= (step == TAPS_M1) ? '0 : step + 1'b1;
        end
        S_WAIT_IN: begin
          if (in_hs) begin
            last_seen <= ss_tlast;
            step      <= '0;
          end
        end
        S_MAC: begin
          if (step == '0)        acc <= '0;
          else if (step >= LAT)  acc <= acc_sum;
          if (step == LAST_K) begin
            step       <= '0;
            wptr       <= (wptr == TAPS_M1) ? '0 : wptr + 1'b1;
            sample_cnt <= cnt_next;
          end else begin
            step <= step + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  fir_out_fifo #(
    .WIDTH (pDATA_WIDTH + 1)
  ) u_out_fifo (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .push       (push),
    .push_data  ({final_sample, acc_sum}),
    .pop        (sm_tvalid && sm_tready),
    .pop_data   (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign sm_tvalid = !fifo_empty;
  assign sm_tdata  = fifo_head[pDATA_WIDTH-1:0];
  assign sm_tlast  = fifo_head[pDATA_WIDTH];

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine with behavioural tap/data BRAMs.
module tb_fir_mac_engine;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        ap_start;
  logic [31:0] data_length;
  logic        ss_tvalid;
  logic [31:0] ss_tdata;
  logic        ss_tlast;
  logic        ss_tready;
  logic        sm_tready;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        tap_EN;
  logic [11:0] tap_A;
  logic [31:0] tap_Do;
  logic        data_EN;
  logic [3:0]  data_WE;
  logic [31:0] data_Di;
  logic [11:0] data_A;
  logic [31:0] data_Do;
  logic        ap_done;
  logic        ap_idle;

  always #5 axis_clk = ~axis_clk;

  fir_mac_engine #(
    .pADDR_WIDTH (12),
    .pDATA_WIDTH (32),
    .Tape_Num    (11)
  ) dut (
    .axis_clk    (axis_clk),
    .axis_rst_n  (axis_rst_n),
    .ap_start    (ap_start),
    .data_length (data_length),
    .ss_tvalid   (ss_tvalid),
    .ss_tdata    (ss_tdata),
    .ss_tlast    (ss_tlast),
    .ss_tready   (ss_tready),
    .sm_tready   (sm_tready),
    .sm_tvalid   (sm_tvalid),
    .sm_tdata    (sm_tdata),
    .sm_tlast    (sm_tlast),
    .tap_EN      (tap_EN),
    .tap_A       (tap_A),
    .tap_Do      (tap_Do),
    .data_EN     (data_EN),
    .data_WE     (data_WE),
    .data_Di     (data_Di),
    .data_A      (data_A),
    .data_Do     (data_Do),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle)
  );

  logic [31:0] tap_mem  [1024];
  logic [31:0] data_mem [1024];

  always @(posedge axis_clk) if (tap_EN) tap_Do <= tap_mem[tap_A[11:2]];

  always @(posedge axis_clk) begin
    if (data_EN) begin
      if (data_WE == 4'hF) data_mem[data_A[11:2]] <= data_Di;
      data_Do <= data_mem[data_A[11:2]];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: records popped outputs, handshakes and ap_done pulses between clock edges.
  int          cyc = 0;
  logic        mon_clr;
  logic [32:0] out_q [$];
  int          hs_cnt, done_cnt, done_pops, first_hs, first_valid;

  always @(posedge axis_clk) cyc <= cyc + 1;

  always @(negedge axis_clk) begin
    if (mon_clr) begin
      out_q.delete();
      hs_cnt      = 0;
      done_cnt    = 0;
      done_pops   = -1;
      first_hs    = -1;
      first_valid = -1;
    end else if (axis_rst_n) begin
      if (sm_tvalid && sm_tready) out_q.push_back({sm_tlast, sm_tdata});
      if (ss_tvalid && ss_tready) begin
        if (hs_cnt == 0) first_hs = cyc;
        hs_cnt++;
      end
      if (sm_tvalid && first_valid < 0) first_valid = cyc;
      if (ap_done) begin
        done_cnt++;
        done_pops = out_q.size();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge axis_clk);
    #1;
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
  endtask

  task automatic set_taps_ramp();
    for (int i = 0; i < 11; i++) tap_mem[i] = 32'(i);
  endtask

  task automatic set_taps_const(input logic [31:0] v);
    for (int i = 0; i < 11; i++) tap_mem[i] = v;
  endtask

  task automatic start_run(input logic [31:0] len);
    mon_clear();
    data_length = len;
    ap_start    = 1'b1;
    tick(1);
    ap_start    = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    ss_tdata  = d;
    ss_tlast  = last;
    ss_tvalid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge axis_clk);
      if (ss_tready) begin
        tick(1);
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        return;
      end
    end
    check("send_timeout", {31'b0, ss_tready}, 32'd1);
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done_cnt != 0) return;
    end
    check("done_timeout", 32'(done_cnt), 32'd1);
  endtask

  task automatic check_out(input string tag, input int idx, input logic [31:0] d, input logic l);
    if (idx < out_q.size()) begin
      check({tag, "_data"}, out_q[idx][31:0], d);
      check({tag, "_last"}, {31'b0, out_q[idx][32]}, {31'b0, l});
    end else begin
      check({tag, "_missing"}, 32'(out_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ss_tready"}, {31'b0, ss_tready}, 32'd0);
    check({tag, "_sm_tvalid"}, {31'b0, sm_tvalid}, 32'd0);
    check({tag, "_sm_tdata"},  sm_tdata,           32'd0);
    check({tag, "_sm_tlast"},  {31'b0, sm_tlast},  32'd0);
    check({tag, "_ap_done"},   {31'b0, ap_done},   32'd0);
    check({tag, "_ap_idle"},   {31'b0, ap_idle},   32'd1);
    check({tag, "_bram_ctl"},  {26'b0, tap_EN, data_EN, data_WE}, 32'd0);
    check({tag, "_bram_addr"}, {8'b0, tap_A, data_A}, 32'd0);
    check({tag, "_data_Di"},   data_Di,            32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axis_rst_n  = 1'b0;
    ap_start    = 1'b0;
    data_length = '0;
    ss_tvalid   = 1'b0;
    ss_tdata    = '0;
    ss_tlast    = 1'b0;
    sm_tready   = 1'b1;
    mon_clr     = 1'b1;
    tick(3);
    @(negedge axis_clk);
    check_reset_outputs("reset");
    tick(1);
    axis_rst_n = 1'b1;
    mon_clr    = 1'b0;
    tick(2);

    // Ramp taps, three samples.
    set_taps_ramp();
    start_run(3);
    send(1, 1'b0);
    send(2, 1'b0);
    send(3, 1'b0);
    wait_done(300);
    tick(2);
    check("t1_count", 32'(out_q.size()), 32'd3);
    check_out("t1_y0", 0, 32'd0, 1'b0);
    check_out("t1_y1", 1, 32'd1, 1'b0);
    check_out("t1_y2", 2, 32'd4, 1'b1);
    check("t1_latency", 32'(first_valid - first_hs), 32'd13);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_done_after_pops", 32'(done_pops), 32'd3);
    check("t1_idle", {31'b0, ap_idle}, 32'd1);

    // Unit taps, 15 samples: ring wrap and cleared history.
    set_taps_const(32'd1);
    start_run(15);
    for (int i = 1; i <= 15; i++) send(32'(i), 1'b0);
    wait_done(500);
    tick(2);
    check("t2_count", 32'(out_q.size()), 32'd15);
    check_out("t2_y0", 0, 32'd1, 1'b0);
    check_out("t2_y1", 1, 32'd3, 1'b0);
    check_out("t2_y10", 10, 32'd66, 1'b0);
    check_out("t2_y11", 11, 32'd77, 1'b0);
    check_out("t2_y14", 14, 32'd110, 1'b1);

    // Output stall: two results queue, input is then back-pressured.
    sm_tready = 1'b0;
    start_run(6);
    fork
      begin
        for (int i = 1; i <= 6; i++) send(32'(10 * i), 1'b0);
      end
      begin
        for (int i = 0; i < 200; i++) begin
          tick(1);
          if (sm_tvalid) break;
        end
        check("t3_first_valid", {31'b0, sm_tvalid}, 32'd1);
        tick(40);
        check("t3_ss_tready", {31'b0, ss_tready}, 32'd0);
        check("t3_accepted", 32'(hs_cnt), 32'd2);
        check("t3_no_pops", 32'(out_q.size()), 32'd0);
        check("t3_head_stable", sm_tdata, 32'd10);
        sm_tready = 1'b1;
      end
    join
    wait_done(500);
    tick(2);
    check("t3_count", 32'(out_q.size()), 32'd6);
    check_out("t3_y0", 0, 32'd10, 1'b0);
    check_out("t3_y1", 1, 32'd30, 1'b0);
    check_out("t3_y2", 2, 32'd60, 1'b0);
    check_out("t3_y3", 3, 32'd100, 1'b0);
    check_out("t3_y4", 4, 32'd150, 1'b0);
    check_out("t3_y5", 5, 32'd210, 1'b1);

    // Wraparound arithmetic with large signed taps.
    set_taps_const(32'h7FFF_FFFF);
    start_run(3);
    send(32'd2, 1'b0);
    send(32'd2, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    wait_done(300);
    tick(2);
    check_out("t4_y0", 0, 32'hFFFF_FFFE, 1'b0);
    check_out("t4_y1", 1, 32'hFFFF_FFFC, 1'b0);
    check_out("t4_y2", 2, 32'h7FFF_FFFD, 1'b1);

    // Reset during MAC of sample 2, then a fresh run must see zeroed history.
    set_taps_ramp();
    start_run(5);
    send(32'd7, 1'b0);
    send(32'd8, 1'b0);
    tick(5);
    axis_rst_n = 1'b0;
    @(negedge axis_clk);
    check_reset_outputs("t5_rst");
    tick(2);
    axis_rst_n = 1'b1;
    tick(20);
    check("t5_no_done", 32'(done_cnt), 32'd0);
    check("t5_idle", {31'b0, ap_idle}, 32'd1);
    start_run(2);
    send(32'd1, 1'b0);
    send(32'd1, 1'b0);
    wait_done(300);
    tick(2);
    check("t5_count", 32'(out_q.size()), 32'd2);
    check_out("t5_y0", 0, 32'd0, 1'b0);
    check_out("t5_y1", 1, 32'd1, 1'b1);

    // Early ss_tlast ends the run before data_length.
    start_run(10);
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b0);
    send(32'd4, 1'b1);
    wait_done(300);
    tick(2);
    check("t6_count", 32'(out_q.size()), 32'd4);
    check_out("t6_y2", 2, 32'd4, 1'b0);
    check_out("t6_y3", 3, 32'd10, 1'b1);
    check("t6_done_cnt", 32'(done_cnt), 32'd1);
    check("t6_ss_tready", {31'b0, ss_tready}, 32'd0);

    // Zero-length run finishes with no outputs.
    start_run(0);
    wait_done(100);
    tick(2);
    check("t7_count", 32'(out_q.size()), 32'd0);
    check("t7_done_cnt", 32'(done_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_mac_engine.md
FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 12, BRAM byte-address width.
REQ-002 SHALL have parameter pDATA_WIDTH, default 32, sample/tap/accumulator width.
REQ-003 SHALL have parameter Tape_Num, default 11, number of taps and data-RAM ring depth.
REQ-004 axis_clk  in  1  clock, all logic on rising edge.
REQ-005 axis_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ap_start  in  1  one-cycle start pulse from config register block.
REQ-007 data_length  in  32  number of samples in this run; sampled on accepted ap_start.
REQ-008 ss_tvalid/ss_tdata/ss_tlast  in  1/32/1; ss_tready  out  1  AXI-Stream input samples.
REQ-009 sm_tready  in  1; sm_tvalid/sm_tdata/sm_tlast  out  1/32/1  AXI-Stream filter outputs.
REQ-010 tap_EN  out  1; tap_A  out  12; tap_Do  in  32  read-only tap BRAM port, 1-cycle read latency.
REQ-011 data_EN  out  1; data_WE  out  4; data_Di  out  32; data_A  out  12; data_Do  in  32  data BRAM port, 1-cycle read latency.
REQ-012 ap_done  out  1  one-cycle pulse at run end; ap_idle  out  1  high in IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, WAIT_IN, MAC, DRAIN.
REQ-014 IDLE: ap_idle=1; ap_start=1 -> latch data_length, zero sample counter and wptr, go CLEAR; ap_start in any other state is ignored.
REQ-015 CLEAR: write 0 to data RAM words 0..Tape_Num-1 (data_WE=4'hF, data_A=4*i), one word per cycle, Tape_Num cycles; then go WAIT_IN, or go DRAIN when latched length is 0.
REQ-016 WAIT_IN: ss_tready=1 only when output FIFO has a free entry; on handshake write ss_tdata to data RAM at 4*wptr in the same cycle, latch ss_tlast, go MAC.
REQ-017 MAC: for k=0..Tape_Num-1, one per cycle, tap_A=4*k, data_A=4*((wptr-k) mod Tape_Num); the accumulator clears at k=0 and adds tap_Do*data_Do one cycle after each read.
REQ-018 Arithmetic: signed 32x32 multiply truncated to low 32 bits; accumulate with 32-bit two's-complement wrap, no saturation.
REQ-019 After the last product is accumulated, push result into the 2-entry output FIFO, advance wptr (Tape_Num-1 wraps to 0), increment sample counter.
REQ-020 Latency: ss handshake in cycle T -> sm_tvalid=1 in cycle T+13 (Tape_Num=11, FIFO empty, sm_tready=1).
REQ-021 Next state after MAC: WAIT_IN if counter < data_length and latched ss_tlast=0, else DRAIN.
REQ-022 sm_tlast=1 on the FIFO entry pushed for the final sample (counter==data_length or ss_tlast seen).
REQ-023 sm_tvalid=1 whenever FIFO non-empty; entry pops on sm_tvalid&&sm_tready; sm_tdata/sm_tlast stable while stalled.
REQ-024 A simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-025 DRAIN: wait until FIFO empty, pulse ap_done for one cycle, go IDLE.
REQ-026 tap_EN and data_EN high only in CLEAR, WAIT_IN handshake cycle and MAC; data_WE=0 outside CLEAR and the write cycle.

Reset
REQ-027 While axis_rst_n=0: FSM IDLE, FIFO empty, accumulator/counter/wptr 0; outputs ss_tready=0, sm_tvalid=0, sm_tdata=0, sm_tlast=0, ap_done=0, ap_idle=1, all BRAM enables/WE/A/Di=0.
REQ-028 Reset mid-run SHALL abandon the run with no ap_done; the next run is cleaned by CLEAR.

Structure
REQ-029 State encodings, Tape_Num default and BRAM latency constant SHALL live in shared package fir_pkg.
REQ-030 The 2-entry output FIFO SHALL be sub-module fir_out_fifo (push/pop/full/empty, 33-bit data+last).

Verification
REQ-031 Taps 0..10, data_length=3, inputs 1,2,3 -> outputs 0,1,4 (first tap 0); tlast only on third output; ap_done once, after the third pop.
REQ-032 Taps all 1, inputs 1..15 -> output 15 = sum(5..15) = 110, checking ring wrap after 11 samples.
REQ-033 sm_tready held 0 for 40 cycles after first output -> ss_tready drops after 2 results queued; outputs resume in order, none lost.
REQ-034 Taps all 0x7FFFFFFF, inputs 2 -> 32-bit wrapped value 0xFFFFFFFE matches model.
REQ-035 Reset asserted during MAC of sample 2 -> all outputs at reset values; new run starts with zeroed history.
REQ-036 ss_tlast on sample 4 with data_length=10 -> sm_tlast on output 4, ap_done follows.
